calonso88_rsa_top: RTL and testbench
====================================

Name: calonso88_rsa_top

Overview:
- Tiny-Tapeout-style top computing an 8-bit RSA modular exponentiation, C = M^E mod N, by square-and-multiply.
- Each modular multiply is an interleaved shift-add with conditional subtract.
- Operands are loaded through a byte-wide register-write port; result and status are read on uo_out through a read-select mux.
- Sits directly on the TT pad ring (ui/uo/uio).

Parameters:
- WIDTH, 8, operand width of M, E, N and C. The pad interface requires 8.

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  design selected; when 0, write/start edges are ignored, computation in flight continues.
- ui_in  in  8  [2:0] write address, [3] write strobe, [4] start, [7:5] read select.
- uio_in  in  8  write data byte.
- uo_out  out  8  read-mux output.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0; all uio pins are inputs.

Behaviour:
- Reset (async, active-high): M=E=N=0, result=0; busy=done=err=0; FSM=IDLE; edge-detect registers=0; uo_out=0.
- Edge detection: ui_in[3] and ui_in[4] are registered once. An event is the 0->1 transition of the registered value, qualified by ena=1.
- Write event in IDLE or DONE: register[addr] <= uio_in. addr 0=M, 1=E, 2=N; addr 3-7 are ignored.
- Write events while busy are ignored.
- Start event while busy is ignored.
- Start event in IDLE/DONE: done<=0, err<=0, busy<=1, FSM->CHECK.
- Simultaneous write and start edges in the same cycle: the write is applied first; start uses the new value.
- CHECK (1 cycle):
  - If N<2 or M>=N: err<=1, result<=0, FSM->DONE.
  - Else: acc<=1, base<=M, bit index<=WIDTH-1, FSM->SQR.
- SQR (WIDTH cycles): acc <= acc*acc mod N, then FSM->MUL.
- MUL (WIDTH cycles): tmp = acc*base mod N.
  - Commit tmp to acc only if E[bit index]=1.
  - The multiply always runs, giving fixed, data-independent latency.
  - If bit index=0: FSM->DONE. Else decrement index, FSM->SQR.
- DONE: result<=acc (or 0 on err), busy<=0, done<=1. done stays sticky until the next accepted start.
- Latency for valid operands:
  - busy rises on the edge after the start event is detected.
  - done rises 1 + 2*WIDTH*WIDTH + 1 cycles later (130 cycles for WIDTH=8).
  - Error path: done rises 2 cycles after busy.
- Modular multiply a*b mod n, with a,b<n. r=0; for i=WIDTH-1 downto 0:
  - r = 2r; if r>=n then r-=n;
  - if b[i]: r+=a; if r>=n then r-=n.
  - Intermediates use WIDTH+1 bits; no overflow since r,a<n<=255.
- E=0 yields 1 (for valid M, N).
- Read mux on ui_in[7:5]:
  - 000: result.
  - 001: status = {5'b0, err, done, busy}.
  - other selects: 0, unless the optional feature is enabled.
- uo_out is registered: it reflects the select and its data one cycle later.
- Reset mid-operation aborts immediately to the reset state.

Optional Feature:
- Macro: RSA_REG_READBACK_EN.
- Defined: read select 010/011/100 returns M/E/N respectively.
- Undefined: those selects return 0, and no readback mux logic is generated.

Decomposition:
- Package rsa_pkg holds:
  - WIDTH;
  - state enum {IDLE, CHECK, SQR, MUL, DONE};
  - register address constants ADDR_M=0, ADDR_E=1, ADDR_N=2;
  - read-select constants SEL_RESULT=0, SEL_STATUS=1, SEL_M=2, SEL_E=3, SEL_N=4.
- One sub-module, rsa_mod_mult: iterative WIDTH-cycle interleaved modular multiplier.
  - Inputs: start, a, b, n.
  - Outputs: r, valid.
  - The top FSM sequences it for SQR (a=b=acc) and MUL (a=acc, b=base).

Test Plan:
- Reset, then read select 000/001 -> uo_out=0x00 and status=0x00; uio_oe=0x00.
- Write M=2, E=7, N=11; pulse start -> busy=1, then done after 130 cycles; result=7 (128 mod 11).
- Write M=4, E=13, N=221; start -> result=4; status=0x02 (done, no err).
- Write M=65, E=0, N=221; start -> result=1.
- Write M=250, N=200 (M>=N); start -> err=1, done=1, result=0, status=0x06. Repeat with N=1 -> same.
- While busy:
  - write E=0xFF -> ignored; the E readback (with RSA_REG_READBACK_EN) still shows the old value;
  - a second start is ignored;
  - asserting rst mid-run -> busy=0, result=0 immediately.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared definitions for the 8-bit RSA modular exponentiator: operand width,
// FSM states, register/read-select encodings and one interleaved modmul step.
package rsa_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        SQR   = 3'd2,
        MUL   = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [2:0] ADDR_M = 3'd0;
    localparam logic [2:0] ADDR_E = 3'd1;
    localparam logic [2:0] ADDR_N = 3'd2;

    localparam logic [2:0] SEL_RESULT = 3'd0;
    localparam logic [2:0] SEL_STATUS = 3'd1;
    localparam logic [2:0] SEL_M      = 3'd2;
    localparam logic [2:0] SEL_E      = 3'd3;
    localparam logic [2:0] SEL_N      = 3'd4;

    // One bit of the interleaved a*b mod n: r = 2r mod n, then conditionally
    // add a mod n. The extra bit holds 2r and r+a, both below 2n <= 510.
    function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] n,
                                                 input logic             b_bit);
        logic [WIDTH:0] t;
        t = {r, 1'b0};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        if (b_bit)          t = t + {1'b0, a};
        if (t >= {1'b0, n}) t = t - {1'b0, n};
        return t[WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rsa_mod_mult.sv
// Iterative WIDTH-cycle interleaved modular multiplier, r = a*b mod n.
// Handshake: start is a one-cycle pulse that samples a, b, n and processes the
// MSB of b in that same cycle; valid is high during the last (WIDTH-th) cycle,
// when r already carries the final product. There is no back-pressure.
module rsa_mod_mult
    import rsa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] r,
    output logic             valid
);

    logic [WIDTH-1:0] a_q, b_q, n_q, r_q;
    logic [IDX_W-1:0] idx_q;
    logic             active_q;
    logic [WIDTH-1:0] step_r;

    // Next partial remainder for the bit currently being processed.
    always_comb begin
        step_r = mm_step(r_q, a_q, n_q, b_q[idx_q]);
    end

    assign r     = step_r;
    assign valid = active_q && (idx_q == '0);

    // Operand capture on start, then one remainder step per cycle down to bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
        end else if (start) begin
            a_q      <= a;
            b_q      <= b;
            n_q      <= n;
            r_q      <= mm_step('0, a, n, b[WIDTH-1]);
            idx_q    <= IDX_W'(WIDTH - 2);
            active_q <= 1'b1;
        end else if (active_q) begin
            r_q <= step_r;
            if (idx_q == '0) active_q <= 1'b0;
            else             idx_q    <= idx_q - 1'b1;
        end
    end

endmodule

// File: rtl/calonso88_rsa_top.sv
// Tiny-Tapeout top: C = M^E mod N by left-to-right square-and-multiply.
// Operands are written over uio_in, start/write are edge-detected on ui_in,
// results and status are read back on uo_out through a registered mux.
// Optional build macro RSA_REG_READBACK_EN adds M/E/N readback selects.
module calonso88_rsa_top
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t           state_q, state_d;
    logic             wr_q, wr_qq, st_q, st_qq;
    logic             wr_ev, st_ev;
    logic [WIDTH-1:0] m_q, e_q, n_q, acc_q, base_q, result_q;
    logic [IDX_W-1:0] bit_q;
    logic             busy_q, done_q, err_q, kick_q;
    logic             operand_err;
    logic [WIDTH-1:0] mm_b, mm_r;
    logic             mm_valid;
    logic [7:0]       rd_data, uo_q;

    assign wr_ev       = ena && wr_q && !wr_qq;
    assign st_ev       = ena && st_q && !st_qq;
    assign operand_err = (n_q < WIDTH'(2)) || (m_q >= n_q);
    assign mm_b        = (state_q == MUL) ? base_q : acc_q;

    rsa_mod_mult u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (kick_q),
        .a     (acc_q),
        .b     (mm_b),
        .n     (n_q),
        .r     (mm_r),
        .valid (mm_valid)
    );

    // Strobe synchronising registers feeding the rising-edge detectors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= 1'b0;
            wr_qq <= 1'b0;
            st_q  <= 1'b0;
            st_qq <= 1'b0;
        end else begin
            wr_q  <= ui_in[3];
            wr_qq <= wr_q;
            st_q  <= ui_in[4];
            st_qq <= st_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic: a square and a multiply per exponent bit, MSB first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (st_ev) state_d = CHECK;
            CHECK:      state_d = operand_err ? DONE : SQR;
            SQR:        if (mm_valid) state_d = MUL;
            MUL:        if (mm_valid) state_d = (bit_q == '0) ? DONE : SQR;
            default:    state_d = IDLE;
        endcase
    end

    // Operand registers, exponentiation datapath and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            base_q   <= '0;
            bit_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            kick_q   <= 1'b0;
        end else begin
            // Launch the multiplier on the first cycle of every SQR/MUL visit.
            kick_q <= ((state_d == SQR) || (state_d == MUL)) && (state_d != state_q);
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == DONE) begin
                        result_q <= err_q ? '0 : acc_q;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                    if (wr_ev) begin
                        case (ui_in[2:0])
                            ADDR_M:  m_q <= uio_in;
                            ADDR_E:  e_q <= uio_in;
                            ADDR_N:  n_q <= uio_in;
                            default: ;
                        endcase
                    end
                    if (st_ev) begin
                        done_q <= 1'b0;
                        err_q  <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (operand_err) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else begin
                        acc_q  <= WIDTH'(1);
                        base_q <= m_q;
                        bit_q  <= IDX_W'(WIDTH - 1);
                    end
                end
                SQR: if (mm_valid) acc_q <= mm_r;
                MUL: begin
                    // The multiply always runs so latency never depends on E.
                    if (mm_valid) begin
                        if (e_q[bit_q])    acc_q <= mm_r;
                        if (bit_q != '0)   bit_q <= bit_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read-select mux in front of the output register.
    always_comb begin
        rd_data = '0;
        case (ui_in[7:5])
            SEL_RESULT: rd_data = result_q;
            SEL_STATUS: rd_data = {5'b0, err_q, done_q, busy_q};
`ifdef RSA_REG_READBACK_EN
            SEL_M:      rd_data = m_q;
            SEL_E:      rd_data = e_q;
            SEL_N:      rd_data = n_q;
`endif
            default:    rd_data = '0;
        endcase
    end

    // Registered output: uo_out follows the select one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) uo_q <= '0;
        else     uo_q <= rd_data;
    end

    assign uo_out  = uo_q;
    assign uio_out = '0;
    assign uio_oe  = '0;

endmodule

// File: tb/tb_calonso88_rsa_top.sv
// Bench for calonso88_rsa_top: vector table of exponentiations plus random
// operands checked against a right-to-left reference, and hand sequences for
// busy-time writes/starts, ena gating and mid-run reset.
module tb_calonso88_rsa_top;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int chk_cnt;
    int err_cnt;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] m;
        logic [7:0] e;
        logic [7:0] n;
        logic [7:0] exp_res;
        logic [7:0] exp_stat;
        int         exp_lat;
    } vec_t;

    vec_t vecs[10];

    calonso88_rsa_top dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_reg(input logic [2:0] addr, input logic [7:0] data);
        ui_in[2:0] = addr;
        uio_in     = data;
        ui_in[3]   = 1'b1;
        tick(3);
        ui_in[3]   = 1'b0;
        tick(2);
    endtask

    task automatic read_sel(input logic [2:0] sel, output logic [7:0] v);
        ui_in[7:5] = sel;
        tick(2);
        v = uo_out;
    endtask

    // Wait for status.done, returning the cycle count (-1 on timeout).
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 400) begin
            tick(1);
            lat++;
            if (uo_out[1]) seen = 1'b1;
        end
        if (!seen) lat = -1;
    endtask

    // Start, measure busy->done, then compare status and result with the queue.
    task automatic run_op(input string name, input logic [7:0] exp_stat, input int exp_lat);
        bit         seen;
        int         lat;
        logic [7:0] v;
        logic [7:0] exp;
        ui_in[7:5] = 3'd1;
        tick(2);
        ui_in[4] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (uo_out[0]) seen = 1'b1;
        end
        ui_in[4] = 1'b0;
        check({name, "_busy"}, 32'(seen), 32'd1);
        wait_done(lat);
        check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        tick(1);
        read_sel(3'd1, v);
        check({name, "_status"}, 32'(v), 32'(exp_stat));
        read_sel(3'd0, v);
        exp = exp_q.pop_front();
        check({name, "_result"}, 32'(v), 32'(exp));
    endtask

    function automatic logic [7:0] model_pow(input logic [7:0] m, input logic [7:0] e,
                                             input logic [7:0] n);
        int r, b;
        r = 1;
        b = int'(m);
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = (r * b) % int'(n);
            b = (b * b) % int'(n);
        end
        return 8'(r);
    endfunction

    initial begin
        logic [7:0] v;
        logic [7:0] rm, re, rn;
        int         lat;

        vecs[0] = '{8'd2,   8'd7,   8'd11,  8'd7,   8'h02, 130};
        vecs[1] = '{8'd4,   8'd13,  8'd221, 8'd4,   8'h02, 130};
        vecs[2] = '{8'd65,  8'd0,   8'd221, 8'd1,   8'h02, 130};
        vecs[3] = '{8'd250, 8'd3,   8'd200, 8'd0,   8'h06, 2};
        vecs[4] = '{8'd250, 8'd3,   8'd1,   8'd0,   8'h06, 2};
        vecs[5] = '{8'd10,  8'd3,   8'd33,  8'd10,  8'h02, 130};
        vecs[6] = '{8'd10,  8'd2,   8'd11,  8'd1,   8'h02, 130};
        vecs[7] = '{8'd1,   8'd200, 8'd2,   8'd1,   8'h02, 130};
        vecs[8] = '{8'd2,   8'd5,   8'd2,   8'd0,   8'h06, 2};
        vecs[9] = '{8'd5,   8'd3,   8'd255, 8'd125, 8'h02, 130};

        chk_cnt = 0;
        err_cnt = 0;
        rst     = 1'b1;
        ena     = 1'b1;
        ui_in   = 8'h00;
        uio_in  = 8'h00;
        tick(3);
        check("rst_uo_out", 32'(uo_out), 32'd0);
        check("rst_uio_oe", 32'(uio_oe), 32'd0);
        check("rst_uio_out", 32'(uio_out), 32'd0);
        rst = 1'b0;
        read_sel(3'd0, v);
        check("rst_result", 32'(v), 32'd0);
        read_sel(3'd1, v);
        check("rst_status", 32'(v), 32'd0);

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            write_reg(3'd0, vecs[i].m);
            write_reg(3'd1, vecs[i].e);
            write_reg(3'd2, vecs[i].n);
            exp_q.push_back(vecs[i].exp_res);
            run_op($sformatf("vec%0d", i), vecs[i].exp_stat, vecs[i].exp_lat);
        end

        // Random valid operands against the reference model.
        for (int i = 0; i < 4; i++) begin
            rn = 8'($urandom_range(2, 255));
            rm = 8'($urandom_range(0, int'(rn) - 1));
            re = 8'($urandom_range(0, 255));
            write_reg(3'd0, rm);
            write_reg(3'd1, re);
            write_reg(3'd2, rn);
            exp_q.push_back(model_pow(rm, re, rn));
            run_op($sformatf("rand%0d", i), 8'h02, 130);
        end

        // Write and start during a run are ignored: 3^5 mod 7 = 5, not 3^255 mod 7 = 6.
        write_reg(3'd0, 8'd3);
        write_reg(3'd1, 8'd5);
        write_reg(3'd2, 8'd7);
        exp_q.push_back(8'd5);
        ui_in[7:5] = 3'd1;
        ui_in[4]   = 1'b1;
        tick(4);
        ui_in[4]   = 1'b0;
        check("busy_seen", 32'(uo_out[0]), 32'd1);
        write_reg(3'd1, 8'hFF);
        ui_in[4] = 1'b1;
        tick(3);
        ui_in[4] = 1'b0;
        ui_in[7:5] = 3'd1;
        wait_done(lat);
        check("busy_done_seen", 32'(lat > 0), 32'd1);
        tick(10);
        read_sel(3'd1, v);
        check("busy_restart_ignored", 32'(v), 32'h02);
        read_sel(3'd0, v);
        check("busy_write_ignored", 32'(v), 32'(exp_q.pop_front()));
        read_sel(3'd3, v);
`ifdef RSA_REG_READBACK_EN
        check("readback_e", 32'(v), 32'd5);
        read_sel(3'd4, v);
        check("readback_n", 32'(v), 32'd7);
`else
        check("sel3_zero", 32'(v), 32'd0);
`endif
        read_sel(3'd7, v);
        check("sel7_zero", 32'(v), 32'd0);

        // Start with ena low is ignored.
        ena      = 1'b0;
        ui_in[4] = 1'b1;
        tick(4);
        ui_in[4] = 1'b0;
        tick(2);
        ena = 1'b1;
        tick(3);
        read_sel(3'd1, v);
        check("ena_gate_status", 32'(v), 32'h02);

        // Reset in the middle of a run.
        ui_in[4] = 1'b1;
        tick(30);
        ui_in[4] = 1'b0;
        check("midrun_busy", 32'(uo_out[0]), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("midrun_rst_uo", 32'(uo_out), 32'd0);
        tick(2);
        rst = 1'b0;
        read_sel(3'd1, v);
        check("midrun_status", 32'(v), 32'd0);
        read_sel(3'd0, v);
        check("midrun_result", 32'(v), 32'd0);
`ifdef RSA_REG_READBACK_EN
        read_sel(3'd2, v);
        check("midrun_m_cleared", 32'(v), 32'd0);
`endif
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
